// File: rtl/td4_sequencer_pkg.sv
// Shared types for the TD4 sequencer: architectural register file, ALU operation
// codes and sequencer states, plus the TD4 opcode decoder.
package td4_sequencer_pkg;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] out;
    logic [3:0] pc;
    logic       carry;
  } regs_t;

  typedef enum logic [3:0] {
    ADD_A_IMM, MOV_A_B, IN_A, MOV_A_IMM, MOV_B_A, ADD_B_IMM,
    IN_B, MOV_B_IMM, OUT_B, OUT_IMM, JNC_IMM, JMP_IMM, INVALID
  } opecode_t;

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, FAULT} seq_state_t;

  // Codes 1000, 1010, 1100 and 1101 have no TD4 meaning.
  function automatic opecode_t decode_opecode(input logic [3:0] code);
    opecode_t op;
    case (code)
      4'b0000: op = ADD_A_IMM;
      4'b0001: op = MOV_A_B;
      4'b0010: op = IN_A;
      4'b0011: op = MOV_A_IMM;
      4'b0100: op = MOV_B_A;
      4'b0101: op = ADD_B_IMM;
      4'b0110: op = IN_B;
      4'b0111: op = MOV_B_IMM;
      4'b1001: op = OUT_B;
      4'b1011: op = OUT_IMM;
      4'b1110: op = JNC_IMM;
      4'b1111: op = JMP_IMM;
      default: op = INVALID;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/td4_sequencer_if.sv
// Sequencer <-> combinational ALU bus: operation, operands and current state out,
// proposed next state back.
interface td4_sequencer_if;
  import td4_sequencer_pkg::*;

  opecode_t   alu_opecode;
  logic [3:0] alu_imm;
  logic [3:0] alu_in;
  regs_t      alu_cur;
  regs_t      alu_next;

  modport master (output alu_opecode, alu_imm, alu_in, alu_cur, input alu_next);
  modport slave  (input alu_opecode, alu_imm, alu_in, alu_cur, output alu_next);
endinterface

// File: rtl/td4_sequencer_prescaler.sv
// Free-running run-rate prescaler: tick is high on the last of every TICK_DIV cycles.
module td4_tick_prescaler #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_reg;

  assign tick = (cnt_reg == LAST);

  always_ff @(posedge clk) begin
    if (rst || tick) cnt_reg <= '0;
    else             cnt_reg <= cnt_reg + 1'b1;
  end
endmodule

// File: rtl/td4_sequencer.sv
// TD4 fetch/decode/execute controller: owns the architectural registers, reads the
// registered program ROM and commits the external ALU's result once per instruction.
module td4_sequencer
  import td4_sequencer_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  input  logic                   step,
  output logic [3:0]             rom_addr,
  input  logic [7:0]             rom_data,
  input  logic [3:0]             in_port,
  td4_sequencer_if.master        alu,
  output logic [3:0]             out_port,
  output logic                   busy,
  output logic                   retire,
  output logic                   fault
);
  seq_state_t state_reg, state_next;
  regs_t      regs_reg;
  logic [7:0] instr_q;
  logic [3:0] in_q;
  logic       tick;

  td4_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign rom_addr = regs_reg.pc;
  assign out_port = regs_reg.out;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next      = state_reg;
    busy            = 1'b0;
    retire          = 1'b0;
    fault           = 1'b0;
    alu.alu_opecode = INVALID;
    alu.alu_imm     = '0;
    alu.alu_in      = '0;
    alu.alu_cur     = '0;
    case (state_reg)
      IDLE: begin
        if (step || (run && tick)) state_next = FETCH;
      end
      FETCH: begin
        busy       = 1'b1;
        state_next = DECODE;
      end
      // rom_data now holds the word addressed during FETCH
      DECODE: begin
        busy = 1'b1;
        if (decode_opecode(rom_data[7:4]) == INVALID) state_next = FAULT;
        else                                          state_next = EXEC;
      end
      EXEC: begin
        busy            = 1'b1;
        retire          = 1'b1;
        alu.alu_opecode = decode_opecode(instr_q[7:4]);
        alu.alu_imm     = instr_q[3:0];
        alu.alu_in      = in_q;
        alu.alu_cur     = regs_reg;
        state_next      = IDLE;
      end
      FAULT: begin
        fault = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_reg <= '0;
      instr_q  <= '0;
      in_q     <= '0;
    end else begin
      if (state_reg == DECODE) begin
        instr_q <= rom_data;
        in_q    <= in_port;
      end
      // the ALU owns pc increment, jumps and carry; commit its result verbatim
      if (retire) regs_reg <= alu.alu_next;
    end
  end
endmodule

// File: tb/tb_td4_sequencer.sv
// Bench for td4_sequencer: two instances (TICK_DIV 1 and 4), each with a TD4 ALU model
// and a 16x8 registered ROM; vector table plus hand-written corner-case sequences.
module tb_td4_sequencer;
  import td4_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // instance 1: TICK_DIV = 1
  logic       run1 = 1'b0, step1 = 1'b0;
  logic [3:0] addr1, in1 = 4'h0, out1;
  logic [7:0] rom1 [16];
  logic [7:0] data1 = 8'h00;
  logic       busy1, retire1, fault1;
  td4_sequencer_if if1();

  td4_sequencer #(.TICK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .run(run1), .step(step1), .rom_addr(addr1), .rom_data(data1),
    .in_port(in1), .alu(if1), .out_port(out1), .busy(busy1), .retire(retire1), .fault(fault1)
  );

  // instance 4: TICK_DIV = 4
  logic       run4 = 1'b0, step4 = 1'b0;
  logic [3:0] addr4, in4 = 4'h0, out4;
  logic [7:0] rom4 [16];
  logic [7:0] data4 = 8'h00;
  logic       busy4, retire4, fault4;
  td4_sequencer_if if4();

  td4_sequencer #(.TICK_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .run(run4), .step(step4), .rom_addr(addr4), .rom_data(data4),
    .in_port(in4), .alu(if4), .out_port(out4), .busy(busy4), .retire(retire4), .fault(fault4)
  );

  always @(posedge clk) begin
    data1 <= rom1[addr1];
    data4 <= rom4[addr4];
  end

  // TD4 ALU reference: carry only from ADD, JNC jumps when carry is clear
  function automatic regs_t alu_f(input opecode_t op, input logic [3:0] imm,
                                  input logic [3:0] inp, input regs_t cur);
    regs_t n;
    n       = cur;
    n.pc    = cur.pc + 4'h1;
    n.carry = 1'b0;
    case (op)
      ADD_A_IMM: {n.carry, n.a} = {1'b0, cur.a} + {1'b0, imm};
      MOV_A_B:   n.a = cur.b;
      IN_A:      n.a = inp;
      MOV_A_IMM: n.a = imm;
      MOV_B_A:   n.b = cur.a;
      ADD_B_IMM: {n.carry, n.b} = {1'b0, cur.b} + {1'b0, imm};
      IN_B:      n.b = inp;
      MOV_B_IMM: n.b = imm;
      OUT_B:     n.out = cur.b;
      OUT_IMM:   n.out = imm;
      JNC_IMM:   if (!cur.carry) n.pc = imm;
      JMP_IMM:   n.pc = imm;
      default:   n = cur;
    endcase
    return n;
  endfunction

  always_comb if1.alu_next = alu_f(if1.alu_opecode, if1.alu_imm, if1.alu_in, if1.alu_cur);
  always_comb if4.alu_next = alu_f(if4.alu_opecode, if4.alu_imm, if4.alu_in, if4.alu_cur);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic regs_t mk(input logic [3:0] a, input logic [3:0] b, input logic [3:0] o,
                               input logic [3:0] pc, input logic c);
    regs_t r;
    r.a = a; r.b = b; r.out = o; r.pc = pc; r.carry = c;
    return r;
  endfunction

  // scoreboard for instance 1: expected state after each retire
  regs_t sb_q[$];
  regs_t exp_r;
  bit    chk_pending = 1'b0;
  int    n_retire = 0;

  always @(negedge clk) begin
    if (chk_pending) begin
      chk_pending = 1'b0;
      exp_r = sb_q.pop_front();
      check("sb_regs", 32'(dut1.regs_reg), 32'(exp_r));
      check("sb_out_port", 32'(out1), 32'(exp_r.out));
      check("sb_rom_addr", 32'(addr1), 32'(exp_r.pc));
      $display("[TB] retire %0d: a=%h b=%h out=%h pc=%h carry=%b", n_retire,
               dut1.regs_reg.a, dut1.regs_reg.b, dut1.regs_reg.out, dut1.regs_reg.pc,
               dut1.regs_reg.carry);
    end
    if (retire1 === 1'b1) begin
      n_retire++;
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected_retire: got retire %0d with no expectation queued", n_retire);
      end else begin
        chk_pending = 1'b1;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic clear_roms();
    for (int i = 0; i < 16; i++) begin
      rom1[i] = 8'h00;
      rom4[i] = 8'h01;
    end
  endtask

  task automatic pulse_step();
    @(negedge clk); step1 = 1'b1;
    @(negedge clk); step1 = 1'b0;
  endtask

  // bounded wait for a retire on instance 1, then one more cycle for the scoreboard
  task automatic wait_retire(input string name);
    int i;
    i = 0;
    while (retire1 !== 1'b1 && i < 12) begin
      @(negedge clk);
      i++;
    end
    check(name, 32'(retire1), 32'(1));
    @(negedge clk);
  endtask

  typedef struct {
    logic [3:0] addr;
    logic [7:0] word;
    logic [3:0] inp;
    regs_t      exp;
  } vec_t;
  vec_t vecs [14];

  initial begin
    int cnt, last, c4;
    clear_roms();

    // reset state
    do_reset();
    check("rst_busy", 32'(busy1), 32'(0));
    check("rst_retire", 32'(retire1), 32'(0));
    check("rst_fault", 32'(fault1), 32'(0));
    check("rst_regs", 32'(dut1.regs_reg), 32'(0));
    check("rst_out_port", 32'(out1), 32'(0));
    check("rst_opecode", 32'(if1.alu_opecode), 32'(INVALID));
    check("rst_state", 32'(dut1.state_reg), 32'(IDLE));

    // 1: single step of OUT 5, cycle-exact
    rom1[0] = 8'hB5;
    sb_q.push_back(mk(4'h0, 4'h0, 4'h5, 4'h1, 1'b0));
    @(negedge clk); step1 = 1'b1;
    check("t1_busy_c0", 32'(busy1), 32'(0));
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk); step1 = 1'b0;
      check("t1_busy", 32'(busy1), 32'(1));
      check("t1_retire", 32'(retire1), 32'(c == 3));
    end
    @(negedge clk);
    check("t1_busy_c4", 32'(busy1), 32'(0));
    check("t1_out_port", 32'(out1), 32'(5));
    check("t1_pc", 32'(addr1), 32'(1));

    // 2: free run, ADD carry then JNC not taken
    do_reset();
    clear_roms();
    rom1[0] = 8'h3F; rom1[1] = 8'h01; rom1[2] = 8'hE0;
    sb_q.push_back(mk(4'hF, 4'h0, 4'h0, 4'h1, 1'b0));
    sb_q.push_back(mk(4'h0, 4'h0, 4'h0, 4'h2, 1'b1));
    sb_q.push_back(mk(4'h0, 4'h0, 4'h0, 4'h3, 1'b0));
    @(negedge clk); run1 = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40 && cnt < 3; i++) begin
      @(negedge clk);
      if (retire1 === 1'b1) cnt++;
    end
    run1 = 1'b0;
    check("t2_retires", 32'(cnt), 32'(3));
    repeat (8) @(negedge clk);
    check("t2_pc", 32'(addr1), 32'(3));

    // table: every opcode class, IN sampling, carry, JNC both ways, pc wrap
    vecs[0]  = '{4'h0, 8'h3A, 4'h0, mk(4'hA, 4'h0, 4'h0, 4'h1, 1'b0)};
    vecs[1]  = '{4'h1, 8'h40, 4'h0, mk(4'hA, 4'hA, 4'h0, 4'h2, 1'b0)};
    vecs[2]  = '{4'h2, 8'h07, 4'h0, mk(4'h1, 4'hA, 4'h0, 4'h3, 1'b1)};
    vecs[3]  = '{4'h3, 8'h53, 4'h0, mk(4'h1, 4'hD, 4'h0, 4'h4, 1'b0)};
    vecs[4]  = '{4'h4, 8'h20, 4'h6, mk(4'h6, 4'hD, 4'h0, 4'h5, 1'b0)};
    vecs[5]  = '{4'h5, 8'h60, 4'h9, mk(4'h6, 4'h9, 4'h0, 4'h6, 1'b0)};
    vecs[6]  = '{4'h6, 8'h90, 4'h0, mk(4'h6, 4'h9, 4'h9, 4'h7, 1'b0)};
    vecs[7]  = '{4'h7, 8'h10, 4'h0, mk(4'h9, 4'h9, 4'h9, 4'h8, 1'b0)};
    vecs[8]  = '{4'h8, 8'h0F, 4'h0, mk(4'h8, 4'h9, 4'h9, 4'h9, 1'b1)};
    vecs[9]  = '{4'h9, 8'hE2, 4'h0, mk(4'h8, 4'h9, 4'h9, 4'hA, 1'b0)};
    vecs[10] = '{4'hA, 8'hED, 4'h0, mk(4'h8, 4'h9, 4'h9, 4'hD, 1'b0)};
    vecs[11] = '{4'hD, 8'h7E, 4'h0, mk(4'h8, 4'hE, 4'h9, 4'hE, 1'b0)};
    vecs[12] = '{4'hE, 8'hBF, 4'h0, mk(4'h8, 4'hE, 4'hF, 4'hF, 1'b0)};
    vecs[13] = '{4'hF, 8'h34, 4'h0, mk(4'h4, 4'hE, 4'hF, 4'h0, 1'b0)};
    do_reset();
    clear_roms();
    foreach (vecs[i]) rom1[vecs[i].addr] = vecs[i].word;
    foreach (vecs[i]) begin
      in1 = vecs[i].inp;
      sb_q.push_back(vecs[i].exp);
      pulse_step();
      wait_retire("tab_retire_timeout");
    end
    in1 = 4'h0;

    // 3: INVALID opcode faults, no commit, sticky until reset
    do_reset();
    clear_roms();
    rom1[0] = 8'h80;
    pulse_step();
    @(negedge clk);
    check("t3_fault_in_decode", 32'(fault1), 32'(0));
    @(negedge clk);
    check("t3_fault", 32'(fault1), 32'(1));
    check("t3_busy", 32'(busy1), 32'(0));
    pulse_step();
    run1 = 1'b1;
    repeat (10) @(negedge clk);
    run1 = 1'b0;
    check("t3_fault_sticky", 32'(fault1), 32'(1));
    check("t3_state", 32'(dut1.state_reg), 32'(FAULT));
    check("t3_regs", 32'(dut1.regs_reg), 32'(0));
    do_reset();
    check("t3_fault_cleared", 32'(fault1), 32'(0));

    // 5: reset during DECODE aborts without commit; next step runs ROM[0]
    clear_roms();
    rom1[0] = 8'h3A; rom1[1] = 8'h3C;
    sb_q.push_back(mk(4'hA, 4'h0, 4'h0, 4'h1, 1'b0));
    pulse_step();
    wait_retire("t5_pre_retire_timeout");
    pulse_step();
    @(negedge clk);
    check("t5_in_decode", 32'(dut1.state_reg), 32'(DECODE));
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("t5_state", 32'(dut1.state_reg), 32'(IDLE));
    check("t5_regs", 32'(dut1.regs_reg), 32'(0));
    check("t5_busy", 32'(busy1), 32'(0));
    sb_q.push_back(mk(4'hA, 4'h0, 4'h0, 4'h1, 1'b0));
    pulse_step();
    wait_retire("t5_retire_timeout");

    // 6: a step arriving during EXEC is dropped
    rom1[1] = 8'h53;
    sb_q.push_back(mk(4'hA, 4'h3, 4'h0, 4'h2, 1'b0));
    cnt = n_retire;
    pulse_step();
    @(negedge clk);
    @(negedge clk);
    check("t6_in_exec", 32'(retire1), 32'(1));
    step1 = 1'b1;
    @(negedge clk); step1 = 1'b0;
    repeat (8) @(negedge clk);
    check("t6_one_retire", 32'(n_retire - cnt), 32'(1));
    check("t6_pc", 32'(addr1), 32'(2));

    // 4: TICK_DIV=4 free run of ADD A,1: retires 4 cycles apart, a counts up
    do_reset();
    clear_roms();
    @(negedge clk); run4 = 1'b1;
    c4 = 0; last = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (retire4 === 1'b1) begin
        check("t4_a_before_retire", 32'(if4.alu_cur.a), 32'(c4 % 16));
        if (c4 > 0) check("t4_spacing", 32'(cyc - last), 32'(4));
        last = cyc;
        c4++;
      end
    end
    run4 = 1'b0;
    check("t4_enough_retires", 32'(c4 >= 12), 32'(1));

    check("sb_drained", 32'(sb_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
